ifid_skid_stage: RTL and testbench
==================================

Name: ifid_skid_stage

Overview:
- Fetch-to-decode pipeline stage with valid/ready handshake and 2-entry skid buffer.
- Accepts 32-bit instruction words and PC+4 from fetch.
- Holds them across decode back-pressure.
- Splits the instruction into MIPS fields and produces immediateIN/U for the immediate extender directly downstream.

Parameters:
- W, 32, instruction and PC width.
- N, 16, immediate field width (bits N-1:0 of instruction).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (branch/jump taken).
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  W  fetched instruction.
- in_pc4  in  W  PC+4 of fetched instruction.
- out_valid  out  1  decode outputs valid.
- out_ready  in  1  decode consumes this cycle.
- out_instr  out  W  held instruction.
- out_pc4  out  W  held PC+4.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- immediateIN  out  N  instr[N-1:0], to extender.
- U  out  1  1 = zero-extend, 0 = sign-extend.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset: state EMPTY; out_valid=0; in_ready=1; main and skid registers (instr, pc4) = 0; all decoded fields therefore 0; U=0.
- Storage: main register (drives outputs) and skid register. Fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
- Registered outputs: in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: fire_in -> main <= input, go ONE.
- ONE, fire_in & fire_out -> main <= input, stay ONE (zero-bubble throughput).
- ONE, fire_in only -> skid <= input, go FULL.
- ONE, fire_out only -> go EMPTY.
- FULL: in_ready=0; fire_out -> main <= skid, go ONE; else hold.
- Latency: input accepted at edge k is visible on outputs after edge k (1 cycle) when not back-pressured.
- Field decode is combinational from the main register; held stable while out_valid & !out_ready.
- U = 1 when opcode is 0x0C (andi), 0x0D (ori), 0x0E (xori) or 0x0F (lui); otherwise 0.
- flush has priority over every handshake event: next state EMPTY, both registers cleared to 0, any same-cycle fire_in discarded, in_ready=1 next cycle.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.
- in_valid with in_ready=0: no state change; fetch must hold data.

Optional Feature:
- Macro IFID_STALL_CNT_EN.
- Defined: extra output port stall_cnt (16 bits). Increments each cycle with out_valid & !out_ready, saturates at 0xFFFF, cleared only by rst_n (not by flush).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then in_instr=0x3C011234 (lui) with in_valid=1, out_ready=1 -> next cycle out_valid=1, opcode=0x0F, rt=1, immediateIN=0x1234, U=1.
- Stream 0x2008F234 (addi), 0x3108F234 (andi), 0x3508F234 (ori) back-to-back with out_ready=1 -> one output per cycle in order; U=0,1,1; immediateIN=0xF234 each.
- Hold out_ready=0, send 3 instructions -> first two accepted, in_ready=0 after second, third held; raise out_ready -> all three emerge in order, none lost or duplicated.
- State FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, opcode=0, flushed input not delivered.
- Assert rst_n=0 between clock edges while FULL -> out_valid=0, in_ready=1 immediately, before next edge.
- With IFID_STALL_CNT_EN: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush -> stall_cnt stays 5.

Source files
------------

// File: rtl/ifid_skid_stage.sv
// Fetch-to-decode stage: valid/ready handshake, 2-entry skid buffer, MIPS field split.
// Optional saturating stall counter on port stall_cnt when IFID_STALL_CNT_EN is defined.
module ifid_skid_stage #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_instr,
  input  logic [W-1:0] in_pc4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_instr,
  output logic [W-1:0] out_pc4,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [5:0]   funct,
  output logic [N-1:0] immediateIN,
  output logic         U,
`ifdef IFID_STALL_CNT_EN
  output logic [15:0]  stall_cnt,
`endif
  output logic [1:0]   dbgState
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, stateNext;
  logic [W-1:0] mainInstr, mainPc4, skidInstr, skidPc4;
  logic [W-1:0] mainInstrNext, mainPc4Next, skidInstrNext, skidPc4Next;
  logic fireIn, fireOut;

  // A transfer happens on an edge where valid and ready are both high; the
  // sender must hold valid and data stable until that edge, and ready depends
  // only on the state register, never on the same-cycle valid.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign fireIn    = in_valid & in_ready;
  assign fireOut   = out_valid & out_ready;
  assign dbgState  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      mainInstr <= '0;
      mainPc4   <= '0;
      skidInstr <= '0;
      skidPc4   <= '0;
    end else begin
      state     <= stateNext;
      mainInstr <= mainInstrNext;
      mainPc4   <= mainPc4Next;
      skidInstr <= skidInstrNext;
      skidPc4   <= skidPc4Next;
    end
  end

  always_comb begin
    stateNext     = state;
    mainInstrNext = mainInstr;
    mainPc4Next   = mainPc4;
    skidInstrNext = skidInstr;
    skidPc4Next   = skidPc4;
    if (flush) begin
      // Flush beats any handshake; a same-cycle input is dropped.
      stateNext     = EMPTY;
      mainInstrNext = '0;
      mainPc4Next   = '0;
      skidInstrNext = '0;
      skidPc4Next   = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (fireIn) begin
            mainInstrNext = in_instr;
            mainPc4Next   = in_pc4;
            stateNext     = ONE;
          end
        end
        ONE: begin
          if (fireIn && fireOut) begin
            mainInstrNext = in_instr;
            mainPc4Next   = in_pc4;
          end else if (fireIn) begin
            skidInstrNext = in_instr;
            skidPc4Next   = in_pc4;
            stateNext     = FULL;
          end else if (fireOut) begin
            stateNext = EMPTY;
          end
        end
        FULL: begin
          if (fireOut) begin
            mainInstrNext = skidInstr;
            mainPc4Next   = skidPc4;
            stateNext     = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  assign out_instr   = mainInstr;
  assign out_pc4     = mainPc4;
  assign opcode      = mainInstr[31:26];
  assign rs          = mainInstr[25:21];
  assign rt          = mainInstr[20:16];
  assign rd          = mainInstr[15:11];
  assign shamt       = mainInstr[10:6];
  assign funct       = mainInstr[5:0];
  assign immediateIN = mainInstr[N-1:0];
  // andi/ori/xori/lui (0x0C..0x0F) take a zero-extended immediate.
  assign U           = (mainInstr[31:28] == 4'b0011);

`ifdef IFID_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage: handshake, skid buffering, flush, async reset, field decode.
// Stall counter checks compile in only when IFID_STALL_CNT_EN is defined.
module tb_ifid_skid_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] immediateIN;
  logic        U;
  logic [1:0]  dbgState;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  ifid_skid_stage #(.W(32), .N(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediateIN(immediateIN), .U(U),
`ifdef IFID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .dbgState(dbgState)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    in_valid = v;
    in_instr = instr;
    in_pc4   = pc4;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_U", {31'b0, U}, 32'd0);
    check("rst_state", {30'b0, dbgState}, 32'd0);
    rst_n = 1'b1;
    step();

    // lui $1,0x1234 with no back-pressure: visible one edge later
    out_ready = 1'b1;
    drive(1'b1, 32'h3C011234, 32'h0000_0004);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("lui_valid", {31'b0, out_valid}, 32'd1);
    check("lui_opcode", {26'b0, opcode}, 32'h0F);
    check("lui_rt", {27'b0, rt}, 32'd1);
    check("lui_imm", {16'b0, immediateIN}, 32'h1234);
    check("lui_U", {31'b0, U}, 32'd1);
    check("lui_pc4", out_pc4, 32'h4);
    step();
    check("lui_drain", {31'b0, out_valid}, 32'd0);

    // Back-to-back stream: one output per cycle
    drive(1'b1, 32'h2008F234, 32'h8);
    step();
    check("addi_instr", out_instr, 32'h2008F234);
    check("addi_U", {31'b0, U}, 32'd0);
    check("addi_rt", {27'b0, rt}, 32'd8);
    check("addi_imm", {16'b0, immediateIN}, 32'hF234);
    drive(1'b1, 32'h3108F234, 32'hC);
    step();
    check("andi_instr", out_instr, 32'h3108F234);
    check("andi_U", {31'b0, U}, 32'd1);
    check("andi_imm", {16'b0, immediateIN}, 32'hF234);
    drive(1'b1, 32'h3508F234, 32'h10);
    step();
    check("ori_instr", out_instr, 32'h3508F234);
    check("ori_U", {31'b0, U}, 32'd1);
    check("ori_imm", {16'b0, immediateIN}, 32'hF234);
    check("ori_pc4", out_pc4, 32'h10);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("stream_drain", {31'b0, out_valid}, 32'd0);

    // Back-pressure: A, B accepted; C held by fetch until space frees
    out_ready = 1'b0;
    drive(1'b1, 32'h012A4020, 32'h20);
    step();
    check("bp_a_instr", out_instr, 32'h012A4020);
    check("bp_a_rs", {27'b0, rs}, 32'd9);
    check("bp_a_rd", {27'b0, rd}, 32'd8);
    check("bp_a_funct", {26'b0, funct}, 32'h20);
    check("bp_one_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h00094080, 32'h24);
    step();
    check("bp_full_ready", {31'b0, in_ready}, 32'd0);
    check("bp_full_state", {30'b0, dbgState}, 32'd2);
    check("bp_a_hold1", out_instr, 32'h012A4020);
    drive(1'b1, 32'h8D280004, 32'h28);
    step();
    check("bp_a_hold2", out_instr, 32'h012A4020);
    check("bp_c_blocked", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_instr", out_instr, 32'h00094080);
    check("bp_b_shamt", {27'b0, shamt}, 32'd2);
    check("bp_b_pc4", out_pc4, 32'h24);
    check("bp_b_ready", {31'b0, in_ready}, 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("bp_c_instr", out_instr, 32'h8D280004);
    check("bp_c_opcode", {26'b0, opcode}, 32'h23);
    check("bp_c_imm", {16'b0, immediateIN}, 32'h0004);
    check("bp_c_pc4", out_pc4, 32'h28);
    step();
    check("bp_drain", {31'b0, out_valid}, 32'd0);

    // Flush from FULL discards the same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 32'h3C01ABCD, 32'h30);
    step();
    drive(1'b1, 32'h3508F234, 32'h34);
    step();
    check("fl_pre_full", {30'b0, dbgState}, 32'd2);
    drive(1'b1, 32'h2008F234, 32'h38);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_ready", {31'b0, in_ready}, 32'd1);
    check("fl_opcode", {26'b0, opcode}, 32'h0);
    check("fl_instr", out_instr, 32'h0);
    out_ready = 1'b1;
    step();
    check("fl_no_deliver", {31'b0, out_valid}, 32'd0);

    // Async reset between edges while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h3C01ABCD, 32'h40);
    step();
    drive(1'b1, 32'h3508F234, 32'h44);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("ar_pre_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_ready", {31'b0, in_ready}, 32'd1);
    check("ar_instr", out_instr, 32'h0);
    check("ar_pc4", out_pc4, 32'h0);
    step();
    rst_n = 1'b1;
    step();

`ifdef IFID_STALL_CNT_EN
    check("sc_reset", {16'b0, stall_cnt}, 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h3C011234, 32'h50);
    step();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    check("sc_five", {16'b0, stall_cnt}, 32'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    check("sc_after_flush", {16'b0, stall_cnt}, 32'd5);
    check("sc_flush_valid", {31'b0, out_valid}, 32'd0);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
